// File: rtl/truth_table_sweeper_pkg.sv
// Shared constants and state encoding for the truth-table sweeper and its settle counter.
package truth_table_sweeper_pkg;

    localparam int VEC_COUNT = 8;
    localparam int CNT_W     = 4;

    // Golden OR/NOR table, bit i = expected result for {a, b, sel} == i.
    localparam logic [7:0] OR_NOR_TABLE = 8'h56;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_WAIT   = ST_WAIT,
        S_SAMPLE = ST_SAMPLE,
        S_DONE   = ST_DONE
    } state_t;

endpackage

// File: rtl/truth_table_sweeper_settle_counter.sv
// Loadable down-counter that times how long each vector is held before sampling.
module settle_counter
    import truth_table_sweeper_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives all eight {a, b, sel} vectors into the OR/NOR selector, captures its result
// into a truth table and compares the table against a golden pattern.
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int         SETTLE   = 1,
    parameter logic [7:0] EXPECTED = OR_NOR_TABLE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       result_in,
    output logic       a,
    output logic       b,
    output logic       sel,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] table_out,
    output logic [3:0] err_cnt,
    output logic [2:0] mismatch_idx
);

    localparam logic [CNT_W-1:0] SETTLE_M1 = CNT_W'(SETTLE - 1);
    localparam logic [2:0]       LAST_IDX  = 3'(VEC_COUNT - 1);

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] table_q, table_d;
    logic [3:0] err_q, err_d, err_next;
    logic [2:0] mis_q, mis_d;
    logic       pass_q, pass_d;
    logic       cnt_load, cnt_dec, cnt_zero;
    logic       bit_bad;

    settle_counter u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (SETTLE_M1),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            table_q <= '0;
            err_q   <= '0;
            mis_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            table_q <= table_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        table_d  = table_q;
        err_d    = err_q;
        mis_d    = mis_q;
        pass_d   = pass_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        bit_bad  = 1'b0;
        err_next = err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                // IDLE keeps results cleared; DONE holds them until a restart.
                if ((state_q == S_IDLE) || start) begin
                    table_d = '0;
                    err_d   = '0;
                    mis_d   = '0;
                    pass_d  = 1'b0;
                end
                if (start) begin
                    state_d  = S_WAIT;
                    idx_d    = '0;
                    cnt_load = 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_zero) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_SAMPLE: begin
                table_d[idx_q] = result_in;
                bit_bad        = (result_in != EXPECTED[idx_q]);
                err_next       = err_q + 4'(bit_bad);
                err_d          = err_next;
                // Only the first error of a sweep records its index.
                if (bit_bad && (err_q == '0)) begin
                    mis_d = idx_q;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                    pass_d  = (err_next == '0);
                end else begin
                    state_d  = S_WAIT;
                    idx_d    = idx_q + 3'd1;
                    cnt_load = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign a            = idx_q[2];
    assign b            = idx_q[1];
    assign sel          = idx_q[0];
    assign busy         = (state_q == S_WAIT) || (state_q == S_SAMPLE);
    assign done         = (state_q == S_DONE);
    assign pass         = pass_q;
    assign table_out    = table_q;
    assign err_cnt      = err_q;
    assign mismatch_idx = mis_q;

endmodule
